// File: rtl/pipe_skid_buffer.sv
// Two-entry elastic pipeline register (main + skid) with registered in_ready.
// softReset flushes in-flight entries, e.g. on a branch mispredict.
module pipe_skid_buffer #(
  parameter int LENGTH = 75
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              softReset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LENGTH-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LENGTH-1:0] out_data,
  output logic [1:0]        count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [LENGTH-1:0] main_q, main_d;
  logic [LENGTH-1:0] skid_q, skid_d;
  logic              in_fire;
  logic              out_fire;

  // Handshake outputs decode straight from the state register.
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign count     = state_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_d  = in_data;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          main_d = in_data;
        end else if (in_fire) begin
          skid_d  = in_data;
          state_d = FULL;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          main_d  = skid_q;
          state_d = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || softReset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule
